// File: rtl/vga_timing_pkg.sv
// Shared timing constants, blanking sentinels and the pixel decode helper
// for the 640x480 @ 60 Hz raster generator (vga_timing_gen).
package vga_timing_pkg;

    // Default timing, in pixel clocks (horizontal) and lines (vertical).
    localparam int DEF_H_VISIBLE  = 640;
    localparam int DEF_H_FP       = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BP       = 48;
    localparam int DEF_V_VISIBLE  = 480;
    localparam int DEF_V_FP       = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BP       = 33;

    // Sync delay: one cycle for the address translator register and one
    // for the video RAM read.
    localparam int DEF_SYNC_DELAY = 2;

    // Constants derived from the defaults; sync windows are inclusive.
    localparam int H_TOTAL      = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL      = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int H_SYNC_START = DEF_H_VISIBLE + DEF_H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;
    localparam int V_SYNC_START = DEF_V_VISIBLE + DEF_V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;

    // Coordinates driven outside the visible area. Both lie beyond any
    // downstream window, so consumers need not gate on video_on.
    localparam logic [9:0] X_BLANK = 10'd1023;
    localparam logic [8:0] Y_BLANK = 9'd511;

    typedef logic [9:0] count_t;

    // Everything the output register stage loads from one (h, v) position.
    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic       video_on;
        logic       frame_start;
        logic       hsync_raw;
        logic       vsync_raw;
    } pixel_decode_t;

    // Combinational decode of a counter position. All comparisons are
    // unsigned on 10-bit values; window bounds are inclusive.
    function automatic pixel_decode_t decode_pixel(
        input count_t h,
        input count_t v,
        input count_t h_visible,
        input count_t v_visible,
        input count_t hs_first,
        input count_t hs_last,
        input count_t vs_first,
        input count_t vs_last
    );
        pixel_decode_t d;
        logic          vis;
        vis           = (h < h_visible) && (v < v_visible);
        d.x           = vis ? h : X_BLANK;
        d.y           = vis ? v[8:0] : Y_BLANK;
        d.video_on    = vis;
        d.frame_start = (h == 10'd0) && (v == 10'd0);
        d.hsync_raw   = !((h >= hs_first) && (h <= hs_last));
        // Depends on the line number only, so it changes at h=0.
        d.vsync_raw   = !((v >= vs_first) && (v <= vs_last));
        return d;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth single-bit shift register used to retime hsync/vsync so they
// line up with colour data returning from the translator and the video RAM.
// DEPTH = 0 is a plain wire. Every stage resets to RST_VAL, so a reset never
// stretches a sync pulse that was already in flight.
module vga_delay_line #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clock25,
    input  logic reset,
    input  logic din,
    output logic dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_pipe
            logic [DEPTH-1:0] stage_reg;

            // Shift din through DEPTH stages; stage 0 is the newest sample.
            always_ff @(posedge clock25) begin
                if (reset) begin
                    stage_reg <= {DEPTH{RST_VAL}};
                end else begin
                    stage_reg[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_reg[i] <= stage_reg[i-1];
                    end
                end
            end

            assign dout = stage_reg[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal/vertical counters, registered
// pixel coordinate / visible / frame-start decode, and active-low syncs
// delayed by SYNC_DELAY cycles (legal range 0..7).
// Optional build macro VGA_TIMING_FRAME_COUNTER_EN enables the 16-bit
// frame counter; without it frame_count is tied to zero.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = DEF_H_VISIBLE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_VISIBLE  = DEF_V_VISIBLE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int SYNC_DELAY = DEF_SYNC_DELAY
) (
    input  logic        clock25,
    input  logic        reset,
    output logic [9:0]  x,
    output logic [8:0]  y,
    output logic        video_on,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic [15:0] frame_count
);

    // Derived from this instance's parameters so a reduced raster works too.
    localparam int     LINE_CYCLES = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int     FRAME_LINES = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam count_t H_LAST      = count_t'(LINE_CYCLES - 1);
    localparam count_t V_LAST      = count_t'(FRAME_LINES - 1);
    localparam count_t H_VIS_END   = count_t'(H_VISIBLE);
    localparam count_t V_VIS_END   = count_t'(V_VISIBLE);
    localparam count_t HS_FIRST    = count_t'(H_VISIBLE + H_FP);
    localparam count_t HS_LAST     = count_t'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam count_t VS_FIRST    = count_t'(V_VISIBLE + V_FP);
    localparam count_t VS_LAST     = count_t'(V_VISIBLE + V_FP + V_SYNC - 1);

    count_t        hcount_reg;
    count_t        hcount_next;
    count_t        vcount_reg;
    count_t        vcount_next;
    pixel_decode_t dec;

    logic [9:0]    x_reg;
    logic [8:0]    y_reg;
    logic          video_on_reg;
    logic          frame_start_reg;
    logic          hsync_raw_reg;
    logic          vsync_raw_reg;

    // Next counter position: h wraps at the end of the line, v steps only
    // on that wrap and itself wraps on the last line of the frame.
    always_comb begin
        hcount_next = hcount_reg + 10'd1;
        vcount_next = vcount_reg;
        if (hcount_reg == H_LAST) begin
            hcount_next = 10'd0;
            vcount_next = (vcount_reg == V_LAST) ? 10'd0 : vcount_reg + 10'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clock25) begin
        if (reset) begin
            hcount_reg <= 10'd0;
            vcount_reg <= 10'd0;
        end else begin
            hcount_reg <= hcount_next;
            vcount_reg <= vcount_next;
        end
    end

    // Decode of the current counter position, loaded into the output stage.
    always_comb begin
        dec = decode_pixel(hcount_reg, vcount_reg, H_VIS_END, V_VIS_END,
                           HS_FIRST, HS_LAST, VS_FIRST, VS_LAST);
    end

    // Output stage: the decode of (h, v) appears one cycle after the counters
    // hold (h, v). Reset forces blanking sentinels and inactive syncs.
    always_ff @(posedge clock25) begin
        if (reset) begin
            x_reg           <= X_BLANK;
            y_reg           <= Y_BLANK;
            video_on_reg    <= 1'b0;
            frame_start_reg <= 1'b0;
            hsync_raw_reg   <= 1'b1;
            vsync_raw_reg   <= 1'b1;
        end else begin
            x_reg           <= dec.x;
            y_reg           <= dec.y;
            video_on_reg    <= dec.video_on;
            frame_start_reg <= dec.frame_start;
            hsync_raw_reg   <= dec.hsync_raw;
            vsync_raw_reg   <= dec.vsync_raw;
        end
    end

    assign x           = x_reg;
    assign y           = y_reg;
    assign video_on    = video_on_reg;
    assign frame_start = frame_start_reg;

    // Syncs only are retimed to meet the colour coming back from the RAM.
    vga_delay_line #(
        .DEPTH   (SYNC_DELAY),
        .RST_VAL (1'b1)
    ) u_hsync_delay (
        .clock25 (clock25),
        .reset   (reset),
        .din     (hsync_raw_reg),
        .dout    (hsync)
    );

    vga_delay_line #(
        .DEPTH   (SYNC_DELAY),
        .RST_VAL (1'b1)
    ) u_vsync_delay (
        .clock25 (clock25),
        .reset   (reset),
        .din     (vsync_raw_reg),
        .dout    (vsync)
    );

`ifdef VGA_TIMING_FRAME_COUNTER_EN
    logic [15:0] frame_count_reg;

    // Count frames on the same edge that loads frame_start high; wraps.
    always_ff @(posedge clock25) begin
        if (reset) begin
            frame_count_reg <= 16'd0;
        end else if (dec.frame_start) begin
            frame_count_reg <= frame_count_reg + 16'd1;
        end
    end

    assign frame_count = frame_count_reg;
`else
    assign frame_count = 16'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen. Horizontal timing is the real
// 800-cycle line; the vertical raster is shortened to 15 lines so several
// complete frames fit in a short run. SYNC_DELAY = 2.
module tb_vga_timing_gen;

    localparam int TB_H_VIS  = 640;
    localparam int TB_H_FP   = 16;
    localparam int TB_H_SYNC = 96;
    localparam int TB_H_BP   = 48;
    localparam int TB_V_VIS  = 8;
    localparam int TB_V_FP   = 2;
    localparam int TB_V_SYNC = 2;
    localparam int TB_V_BP   = 3;
    localparam int TB_D      = 2;
    localparam int TB_H_TOT  = TB_H_VIS + TB_H_FP + TB_H_SYNC + TB_H_BP;
    localparam int TB_V_TOT  = TB_V_VIS + TB_V_FP + TB_V_SYNC + TB_V_BP;

    logic        clock25 = 1'b0;
    logic        reset   = 1'b1;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        video_on;
    logic        frame_start;
    logic        hsync;
    logic        vsync;
    logic [15:0] frame_count;

    always #20 clock25 = ~clock25;

    vga_timing_gen #(
        .H_VISIBLE  (TB_H_VIS),
        .H_FP       (TB_H_FP),
        .H_SYNC     (TB_H_SYNC),
        .H_BP       (TB_H_BP),
        .V_VISIBLE  (TB_V_VIS),
        .V_FP       (TB_V_FP),
        .V_SYNC     (TB_V_SYNC),
        .V_BP       (TB_V_BP),
        .SYNC_DELAY (TB_D)
    ) dut (
        .clock25     (clock25),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .video_on    (video_on),
        .frame_start (frame_start),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_count (frame_count)
    );

    typedef struct packed {
        logic [9:0]  x;
        logic [8:0]  y;
        logic        vo;
        logic        fs;
        logic        hs;
        logic        vs;
        logic [15:0] fc;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference raster state.
    int          m_h = 0;
    int          m_v = 0;
    logic [7:0]  hs_hist = 8'hFF;
    logic [7:0]  vs_hist = 8'hFF;
    logic [15:0] m_fc = 16'd0;

    // Measurements taken from observed outputs during the free run.
    int cyc       = 0;
    int prev_x    = 1023;
    logic prev_hs = 1'b1;
    logic prev_vs = 1'b1;
    int last_x0   = -1;
    int line_per  = -1;
    int hs_fall   = -1;
    int hs_ofs    = -1;
    int hs_len    = -1;
    int vs_fall   = -1;
    int vs_len    = -1;
    int last_fs   = -1;
    int fs_per    = -1;
    int n_fs      = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, want, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Build the expected outputs for the next edge from the reference raster,
    // push them, apply the edge, then pop and compare against the DUT.
    task automatic drive_cycle(input logic rst);
        exp_t e;
        logic vis;
        reset = rst;
        if (rst) begin
            e.x  = 10'd1023;
            e.y  = 9'd511;
            e.vo = 1'b0;
            e.fs = 1'b0;
            hs_hist = 8'hFF;
            vs_hist = 8'hFF;
            m_fc = 16'd0;
            e.hs = 1'b1;
            e.vs = 1'b1;
            e.fc = 16'd0;
            m_h = 0;
            m_v = 0;
        end else begin
            vis  = (m_h < TB_H_VIS) && (m_v < TB_V_VIS);
            e.x  = vis ? 10'(m_h) : 10'd1023;
            e.y  = vis ? 9'(m_v) : 9'd511;
            e.vo = vis;
            e.fs = (m_h == 0) && (m_v == 0);
            hs_hist = {hs_hist[6:0],
                       !((m_h >= TB_H_VIS + TB_H_FP) && (m_h < TB_H_VIS + TB_H_FP + TB_H_SYNC))};
            vs_hist = {vs_hist[6:0],
                       !((m_v >= TB_V_VIS + TB_V_FP) && (m_v < TB_V_VIS + TB_V_FP + TB_V_SYNC))};
            e.hs = hs_hist[TB_D];
            e.vs = vs_hist[TB_D];
`ifdef VGA_TIMING_FRAME_COUNTER_EN
            if (e.fs) m_fc = m_fc + 16'd1;
`endif
            e.fc = m_fc;
            m_h = m_h + 1;
            if (m_h == TB_H_TOT) begin
                m_h = 0;
                m_v = (m_v == TB_V_TOT - 1) ? 0 : m_v + 1;
            end
        end
        exp_q.push_back(e);
        @(posedge clock25);
        #1;
        if (exp_q.size() == 0) begin
            check_val("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_val("x",           32'(x),           32'(e.x));
            check_val("y",           32'(y),           32'(e.y));
            check_val("video_on",    32'(video_on),    32'(e.vo));
            check_val("frame_start", 32'(frame_start), 32'(e.fs));
            check_val("hsync",       32'(hsync),       32'(e.hs));
            check_val("vsync",       32'(vsync),       32'(e.vs));
            check_val("frame_count", 32'(frame_count), 32'(e.fc));
        end
    endtask

    // Record line period, sync offsets/widths and frame period.
    task automatic measure();
        if (x == 10'd0 && prev_x != 0) begin
            if (last_x0 >= 0 && line_per < 0) line_per = cyc - last_x0;
            last_x0 = cyc;
        end
        if (prev_hs && !hsync && hs_fall < 0) begin
            hs_fall = cyc;
            hs_ofs  = cyc - last_x0;
        end
        if (!prev_hs && hsync && hs_len < 0 && hs_fall >= 0) hs_len = cyc - hs_fall;
        if (prev_vs && !vsync && vs_fall < 0) vs_fall = cyc;
        if (!prev_vs && vsync && vs_len < 0 && vs_fall >= 0) vs_len = cyc - vs_fall;
        if (frame_start) begin
            if (last_fs >= 0 && fs_per < 0) fs_per = cyc - last_fs;
            last_fs = cyc;
            n_fs++;
            $display("frame_start at cycle %0d, frame_count=%0d", cyc, frame_count);
        end
        prev_x  = int'(x);
        prev_hs = hsync;
        prev_vs = vsync;
        cyc++;
    endtask

    initial begin
        int guard;

        // Reset held for five cycles.
        for (int i = 0; i < 5; i++) drive_cycle(1'b1);
        $display("reset phase done: x=%0d y=%0d hsync=%0b vsync=%0b", x, y, hsync, vsync);

        // Three full frames from release.
        for (int i = 0; i < 3 * TB_H_TOT * TB_V_TOT; i++) begin
            drive_cycle(1'b0);
            measure();
        end
        check_val("line_period",  32'(line_per), 32'(TB_H_TOT));
        check_val("hsync_offset", 32'(hs_ofs),   32'(TB_H_VIS + TB_H_FP + TB_D));
        check_val("hsync_width",  32'(hs_len),   32'(TB_H_SYNC));
        check_val("vsync_width",  32'(vs_len),   32'(TB_V_SYNC * TB_H_TOT));
        check_val("frame_period", 32'(fs_per),   32'(TB_H_TOT * TB_V_TOT));
        check_val("frame_starts", 32'(n_fs),     32'd3);
`ifdef VGA_TIMING_FRAME_COUNTER_EN
        check_val("frames_counted", 32'(frame_count), 32'd3);
`else
        check_val("frames_counted", 32'(frame_count), 32'd0);
`endif
        $display("free run done: %0d cycles, line=%0d hs_ofs=%0d hs_w=%0d vs_w=%0d", cyc, line_per, hs_ofs, hs_len, vs_len);

        // Run to line 10, column 700, inside the hsync pulse, then reset.
        guard = 0;
        while (!(m_h == 700 && m_v == 10) && guard < 20000) begin
            drive_cycle(1'b0);
            guard++;
        end
        check_val("reach_mid_line", 32'(guard < 20000), 32'd1);
        check_val("pre_rst_hsync", 32'(hsync), 32'd0);
        drive_cycle(1'b1);
        check_val("mid_rst_hsync", 32'(hsync), 32'd1);
        check_val("mid_rst_x", 32'(x), 32'd1023);
        $display("mid-frame reset applied at line 10 col 700");
        drive_cycle(1'b0);
        check_val("restart_x",  32'(x), 32'd0);
        check_val("restart_y",  32'(y), 32'd0);
        check_val("restart_fs", 32'(frame_start), 32'd1);
        for (int i = 0; i < 1000; i++) drive_cycle(1'b0);
        $display("post-reset run done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Upstream raster stage for the 640x480 @ 60 Hz VGA path, clocked at 25 MHz.
- Keeps the horizontal and vertical counters and drives the pixel coordinates x/y that feed the address translator.
- Produces active-low hsync/vsync, delayed by SYNC_DELAY cycles. This delay makes the syncs line up with the colour that returns through the translator register and the video RAM read.
- Also produces a visible-area flag and a frame-start pulse.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, hsync pulse width (cycles)
- H_BP, 48, horizontal back porch (cycles)
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_DELAY, 2, extra cycles applied to hsync/vsync only (1 translator + 1 RAM); legal range 0..7

Ports:
- clock25, input, 1, 25 MHz pixel clock (single clock domain)
- reset, input, 1, synchronous, active-high
- x, output, 10, pixel column; 10'd1023 outside the visible area
- y, output, 9, pixel row; 9'd511 outside the visible area
- video_on, output, 1, high when (x,y) is a visible pixel
- frame_start, output, 1, one-cycle pulse aligned with x=0,y=0
- hsync, output, 1, active-low, delayed by SYNC_DELAY relative to x/y
- vsync, output, 1, active-low, delayed by SYNC_DELAY relative to x/y
- frame_count, output, 16, frames since reset (optional feature)

Behaviour:
- Interface: one clock, clock25. reset is synchronous and active-high, sampled only on the rising edge of clock25.
- Counters:
  - hcount is 10 bits and counts 0..H_TOTAL-1 (H_TOTAL = 800).
  - vcount is 10 bits and counts 0..V_TOTAL-1 (V_TOTAL = 525).
  - hcount wraps 799→0. vcount increments only when hcount wraps, and wraps 524→0 on the same edge that hcount wraps.
- Registered decode: every output is a register loaded from a decode of the counter values before the edge. The decode of count (h,v) is therefore visible one cycle after the counters hold (h,v).
- Decode rules:
  - visible = (h < H_VISIBLE) && (v < V_VISIBLE).
  - x = visible ? h : 1023. y = visible ? v[8:0] : 511. The sentinels sit outside every downstream window.
  - video_on = visible.
  - frame_start = (h==0 && v==0).
  - hsync_raw = 0 for h in [656, 751], else 1.
  - vsync_raw = 0 for v in [490, 491], else 1. vsync_raw is a whole-line decode; it changes at h=0.
- Sync delay: hsync/vsync are hsync_raw/vsync_raw passed through a SYNC_DELAY-stage shift register. SYNC_DELAY=0 means the syncs are aligned with x/y.
- Reset values (all outputs and internal state):
  - hcount=0, vcount=0.
  - x=1023, y=511, video_on=0, frame_start=0.
  - hsync=1, vsync=1, every delay stage=1, frame_count=0.
- Reset release: the first edge after release loads the decode of (0,0): x=0, y=0, video_on=1, frame_start=1.
- Reset mid-frame: all state returns to the reset values on the next edge. No partial sync pulse may be extended, because the delay stages are forced to 1.
- Width rule: comparisons are unsigned on 10-bit counters. Derived constants (H_TOTAL, sync start/end) are computed from the parameters, not hard-coded.

Optional Feature:
- Macro: VGA_TIMING_FRAME_COUNTER_EN.
- Defined: frame_count increments by 1 on each cycle that frame_start is loaded high, and wraps 0xFFFF→0.
- Not defined: frame_count is tied to 16'd0 and no counter register is inferred.
- The port list is the same in both builds.

Decomposition:
- vga_timing_pkg holds:
  - the eight timing default constants
  - derived H_TOTAL, V_TOTAL, H_SYNC_START/END, V_SYNC_START/END
  - X_BLANK=1023, Y_BLANK=511
- Sub-module vga_delay_line (parameter DEPTH, reset value 1) implements the sync shift register; it is instanced once per sync.

Test Plan:
- Reset held 5 cycles, then released → during reset x=1023, y=511, hsync=vsync=1, video_on=0. First edge after release: x=0, y=0, frame_start=1.
- Free run one line, SYNC_DELAY=2 → x counts 0..639 then 1023 for 160 cycles. hsync low for exactly 96 cycles, starting 656+2 cycles after x=0. Line period is 800.
- Free run one frame → vsync low for exactly 1600 cycles (lines 490–491). frame_start period is 420000 cycles. y holds 511 for lines 480..524.
- Boundary check → at the last visible pixel x=639, y=479, video_on=1; on the next cycle x=1023, video_on=0. After line 524, col 799: next x=0, y=0, frame_start=1.
- Reset asserted mid-hsync pulse (line 100, col 700) → hsync=1 on the next edge; the counters restart from (0,0).
- Build with VGA_TIMING_FRAME_COUNTER_EN, run 3 frames → frame_count=3. Without the macro → frame_count remains 0.
